// File: rtl/pov_text_scanner_if.sv
// Text scanner bus: UART byte input, scan controls and font-ROM side outputs.
// No latency of its own; pure signal bundle.
// No backpressure: rx strobes are accepted unconditionally.
interface pov_text_scanner_if #(
  parameter int TEXT_LEN = 16,
  parameter int ADDR_W   = 10
);
  localparam int IDX_W = $clog2(TEXT_LEN);

  logic              dir;
  logic              scroll_en;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] font_addr;
  logic              blank;
  logic              col_tick;
  logic [IDX_W-1:0]  char_idx;
  logic [IDX_W-1:0]  wr_ptr;

  // Driver side: UART receiver and scan controls.
  modport master (
    output dir, scroll_en, rx_valid, rx_byte,
    input  font_addr, blank, col_tick, char_idx, wr_ptr
  );

  // Scanner side.
  modport slave (
    input  dir, scroll_en, rx_valid, rx_byte,
    output font_addr, blank, col_tick, char_idx, wr_ptr
  );
endinterface

// File: rtl/pov_text_scanner.sv
// POV text engine: UART-loaded text buffer scanned column by column into font-ROM addresses.
// Latency: font_addr/blank/char_idx registered one clock after the counter state they reflect.
// Backpressure: none; every rx_valid strobe is consumed in the cycle it arrives.
module pov_text_scanner #(
  parameter int         TEXT_LEN      = 16,
  parameter int         COLS_PER_CHAR = 6,
  parameter int         GAP_COLS      = 0,
  parameter int         DIV_COEF      = 6000,
  parameter logic [7:0] FONT_BASE     = 8'h20,
  parameter int         ADDR_W        = 10
) (
  input logic                CLK12M,
  input logic                nrst,
  pov_text_scanner_if.slave  bus
);
  localparam int IDX_W  = $clog2(TEXT_LEN);
  localparam int IDX_X  = IDX_W + 1;
  localparam int CT     = COLS_PER_CHAR + GAP_COLS;
  localparam int COL_W  = $clog2(CT + 1);
  localparam int DIV_W  = $clog2(DIV_COEF + 1);
  localparam int GLY_W  = ADDR_W - 3;

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(DIV_COEF);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(CT - 1);
  localparam logic [COL_W-1:0] COL_GLYPH = COL_W'(COLS_PER_CHAR);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TEXT_LEN - 1);
  localparam logic [IDX_X-1:0] LEN_X     = IDX_X'(TEXT_LEN);
  localparam logic [2:0]       GC_LAST   = 3'(COLS_PER_CHAR - 1);

  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [COL_W-1:0]  col;
  logic [IDX_W-1:0]  pos;
  logic [IDX_W-1:0]  offset;
  logic              dir_q;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [7:0]        text [TEXT_LEN];

  logic [IDX_W-1:0]  lidx;
  logic [IDX_X-1:0]  sum;
  logic [IDX_W-1:0]  bidx;
  logic [7:0]        cur;
  logic              in_font;
  logic [GLY_W-1:0]  glyph;
  logic [2:0]        gcol;
  logic              is_gap;

  logic [ADDR_W-1:0] font_addr_q;
  logic              blank_q;
  logic [IDX_W-1:0]  char_idx_q;

  // Column tick is decoded straight from the divider so it lines up with the wrap cycle.
  assign tick = (div == DIV_MAX);

  // Column-period divider: 0..DIV_COEF, then back to 0.
  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) begin
      div <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
    end
  end

  // Column / character / scroll-offset counters; direction is latched with each tick.
  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) begin
      col    <= '0;
      pos    <= '0;
      offset <= '0;
      dir_q  <= 1'b0;
    end else if (tick) begin
      dir_q <= bus.dir;
      if (col == COL_LAST) begin
        col <= '0;
        if (pos == IDX_LAST) begin
          pos <= '0;
          if (bus.scroll_en) begin
            offset <= (offset == IDX_LAST) ? '0 : offset + IDX_W'(1);
          end
        end else begin
          pos <= pos + IDX_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Map scan position to buffer slot and glyph column; modulo by compare-subtract.
  always_comb begin
    lidx    = dir_q ? (IDX_LAST - pos) : pos;
    sum     = IDX_X'(lidx) + IDX_X'(offset);
    bidx    = (sum >= LEN_X) ? IDX_W'(sum - LEN_X) : IDX_W'(sum);
    cur     = text[bidx];
    in_font = (cur >= FONT_BASE) && (cur < 8'h80);
    glyph   = in_font ? GLY_W'(cur - FONT_BASE) : '0;
    gcol    = dir_q ? (GC_LAST - 3'(col)) : 3'(col);
    is_gap  = (col >= COL_GLYPH);
  end

  // Output register: gap columns force a blank address so the ROM reads the space glyph.
  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) begin
      font_addr_q <= '0;
      blank_q     <= 1'b0;
      char_idx_q  <= '0;
    end else begin
      font_addr_q <= is_gap ? '0 : {glyph, gcol};
      blank_q     <= is_gap;
      char_idx_q  <= bidx;
    end
  end

  // Text buffer loader: CR homes, ESC clears, BS erases backwards, anything else is stored.
  always_ff @(posedge CLK12M or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < TEXT_LEN; i++) begin
        text[i] <= 8'h20;
      end
      wr_ptr_q <= '0;
    end else if (bus.rx_valid) begin
      case (bus.rx_byte)
        8'h0D: begin
          wr_ptr_q <= '0;
        end
        8'h1B: begin
          for (int i = 0; i < TEXT_LEN; i++) begin
            text[i] <= 8'h20;
          end
          wr_ptr_q <= '0;
        end
        8'h08: begin
          if (wr_ptr_q != '0) begin
            wr_ptr_q                    <= wr_ptr_q - IDX_W'(1);
            text[wr_ptr_q - IDX_W'(1)]  <= 8'h20;
          end
        end
        default: begin
          text[wr_ptr_q] <= bus.rx_byte;
          wr_ptr_q       <= (wr_ptr_q == IDX_LAST) ? '0 : wr_ptr_q + IDX_W'(1);
        end
      endcase
    end
  end

  assign bus.font_addr = font_addr_q;
  assign bus.blank     = blank_q;
  assign bus.col_tick  = tick;
  assign bus.char_idx  = char_idx_q;
  assign bus.wr_ptr    = wr_ptr_q;
endmodule

// File: tb/tb_pov_text_scanner.sv
// Bench for pov_text_scanner: two instances (no gap / two gap columns) share clock, reset and stimulus.
// Expected outputs per column tick come from a spec-level model and are queued before the ticks occur.
module tb_pov_text_scanner;
  localparam int TL   = 4;
  localparam int CPC  = 6;
  localparam int DIVC = 3;
  localparam int AW   = 10;

  logic       clk = 1'b0;
  logic       nrst;
  logic       dir;
  logic       scroll_en;
  logic       rx_valid;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  pov_text_scanner_if #(.TEXT_LEN(TL), .ADDR_W(AW)) bus0 ();
  pov_text_scanner_if #(.TEXT_LEN(TL), .ADDR_W(AW)) bus1 ();

  assign bus0.dir = dir;       assign bus1.dir = dir;
  assign bus0.scroll_en = scroll_en; assign bus1.scroll_en = scroll_en;
  assign bus0.rx_valid = rx_valid;   assign bus1.rx_valid = rx_valid;
  assign bus0.rx_byte = rx_byte;     assign bus1.rx_byte = rx_byte;

  pov_text_scanner #(.TEXT_LEN(TL), .COLS_PER_CHAR(CPC), .GAP_COLS(0), .DIV_COEF(DIVC),
                     .FONT_BASE(8'h20), .ADDR_W(AW))
    dut0 (.CLK12M(clk), .nrst(nrst), .bus(bus0));

  pov_text_scanner #(.TEXT_LEN(TL), .COLS_PER_CHAR(CPC), .GAP_COLS(2), .DIV_COEF(DIVC),
                     .FONT_BASE(8'h20), .ADDR_W(AW))
    dut1 (.CLK12M(clk), .nrst(nrst), .bus(bus1));

  int tests_run = 0;
  int tests_failed = 0;
  int tick_cnt = 0;
  int last_n = 0;
  int since_tick = 0;
  int period = 0;
  bit got_tick = 1'b0;
  bit saw_tick = 1'b0;
  bit have_period = 1'b0;
  logic [7:0] txt [TL];

  typedef struct {
    int            n;
    logic [AW-1:0] a0;
    logic [1:0]    i0;
    logic          b0;
    logic [AW-1:0] a1;
    logic [1:0]    i1;
    logic          b1;
  } exp_t;
  exp_t sb[$];

  // One clock: sample at the falling edge, track tick index and tick spacing.
  task automatic step();
    @(negedge clk);
    since_tick++;
    got_tick = (bus0.col_tick === 1'b1);
    if (got_tick) begin
      last_n      = tick_cnt;
      tick_cnt++;
      period      = since_tick;
      have_period = saw_tick;
      saw_tick    = 1'b1;
      since_tick  = 0;
    end
  endtask

  task automatic release_reset();
    nrst = 1'b1;
    tick_cnt = 0;
    since_tick = 0;
    saw_tick = 1'b0;
    have_period = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    nrst = 1'b0;
    step();
    step();
    release_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic set_txt(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
    txt[0] = c0; txt[1] = c1; txt[2] = c2; txt[3] = c3;
  endtask

  // Expected outputs shown at the n-th column tick after reset (state after n prior ticks).
  function automatic void model(input int n, input int ct, input bit dv, input bit sc,
                                output logic [AW-1:0] a, output logic [1:0] idx, output logic b);
    int col, ch, pos, off, l, bi, cc, g;
    bit d;
    logic [7:0] c;
    col = n % ct;
    ch  = n / ct;
    pos = ch % TL;
    off = sc ? (ch / TL) % TL : 0;
    d   = (n >= 1) ? dv : 1'b0;
    l   = d ? (TL - 1 - pos) : pos;
    bi  = (l + off) % TL;
    c   = txt[bi];
    g   = (c < 8'h20 || c >= 8'h80) ? 0 : int'(c) - 32;
    cc  = d ? (CPC - 1 - col) : col;
    b   = (col >= CPC);
    idx = 2'(bi);
    a   = b ? '0 : AW'(g * 8 + cc);
  endfunction

  task automatic run_ticks(input int count, input bit dv, input bit sc, input string tag);
    int first;
    int budget;
    exp_t e;
    step();
    step();
    first = tick_cnt;
    for (int k = 0; k < count; k++) begin
      e.n = first + k;
      model(e.n, CPC, dv, sc, e.a0, e.i0, e.b0);
      model(e.n, CPC + 2, dv, sc, e.a1, e.i1, e.b1);
      sb.push_back(e);
    end
    budget = count * (DIVC + 1) + 20;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
      if (got_tick) begin
        e = sb.pop_front();
        tests_run++;
        if (bus0.font_addr !== e.a0 || bus0.char_idx !== e.i0 || bus0.blank !== e.b0) begin
          tests_failed++;
          $display("FAIL %s gap0 tick %0d: addr=%h idx=%0d blank=%b, expected addr=%h idx=%0d blank=%b",
                   tag, last_n, bus0.font_addr, bus0.char_idx, bus0.blank, e.a0, e.i0, e.b0);
        end
        tests_run++;
        if (bus1.font_addr !== e.a1 || bus1.char_idx !== e.i1 || bus1.blank !== e.b1) begin
          tests_failed++;
          $display("FAIL %s gap2 tick %0d: addr=%h idx=%0d blank=%b, expected addr=%h idx=%0d blank=%b",
                   tag, last_n, bus1.font_addr, bus1.char_idx, bus1.blank, e.a1, e.i1, e.b1);
        end
        if (have_period) begin
          tests_run++;
          if (period != DIVC + 1) begin
            tests_failed++;
            $display("FAIL %s tick_period: got %0d clocks, expected %0d", tag, period, DIVC + 1);
          end
        end
      end
    end
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s tick_timeout: %0d ticks missing", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_wr_ptr(input logic [1:0] want, input string tag);
    tests_run++;
    if (bus0.wr_ptr !== want || bus1.wr_ptr !== want) begin
      tests_failed++;
      $display("FAIL %s wr_ptr: got %0d/%0d, expected %0d", tag, bus0.wr_ptr, bus1.wr_ptr, want);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    tests_run++;
    if (bus0.font_addr !== '0 || bus0.blank !== 1'b0 || bus0.col_tick !== 1'b0 ||
        bus0.char_idx !== '0 || bus0.wr_ptr !== '0 ||
        bus1.font_addr !== '0 || bus1.blank !== 1'b0 || bus1.col_tick !== 1'b0 ||
        bus1.char_idx !== '0 || bus1.wr_ptr !== '0) begin
      tests_failed++;
      $display("FAIL %s outputs: addr=%h/%h blank=%b/%b tick=%b/%b idx=%0d/%0d wr=%0d/%0d, expected all 0",
               tag, bus0.font_addr, bus1.font_addr, bus0.blank, bus1.blank, bus0.col_tick, bus1.col_tick,
               bus0.char_idx, bus1.char_idx, bus0.wr_ptr, bus1.wr_ptr);
    end
  endtask

  task automatic test_reset();
    dir = 1'b0;
    scroll_en = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    nrst = 1'b0;
    step();
    check_zero_outputs("reset");
    step();
    release_reset();
    set_txt(8'h20, 8'h20, 8'h20, 8'h20);
    run_ticks(26, 1'b0, 1'b0, "empty");
  endtask

  task automatic test_forward();
    dir = 1'b0;
    scroll_en = 1'b0;
    do_reset();
    send_byte(8'h41); check_wr_ptr(2'd1, "fwd_A");
    send_byte(8'h42); check_wr_ptr(2'd2, "fwd_B");
    send_byte(8'h0D); check_wr_ptr(2'd0, "fwd_CR");
    set_txt(8'h41, 8'h42, 8'h20, 8'h20);
    run_ticks(34, 1'b0, 1'b0, "fwd");
  endtask

  task automatic test_reverse();
    dir = 1'b1;
    scroll_en = 1'b0;
    do_reset();
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h0D);
    set_txt(8'h41, 8'h42, 8'h20, 8'h20);
    run_ticks(34, 1'b1, 1'b0, "rev");
  endtask

  task automatic test_scroll();
    dir = 1'b0;
    scroll_en = 1'b1;
    do_reset();
    send_byte(8'h57);
    send_byte(8'h58);
    send_byte(8'h59);
    send_byte(8'h5A);
    check_wr_ptr(2'd0, "scroll_wrap");
    set_txt(8'h57, 8'h58, 8'h59, 8'h5A);
    run_ticks(136, 1'b0, 1'b1, "scroll");
  endtask

  task automatic test_edit();
    dir = 1'b0;
    scroll_en = 1'b0;
    do_reset();
    send_byte(8'h51);
    send_byte(8'h52); check_wr_ptr(2'd2, "edit_QR");
    send_byte(8'h08); check_wr_ptr(2'd1, "edit_BS");
    set_txt(8'h51, 8'h20, 8'h20, 8'h20);
    run_ticks(24, 1'b0, 1'b0, "edit_bs");
    send_byte(8'h1B); check_wr_ptr(2'd0, "edit_ESC");
    set_txt(8'h20, 8'h20, 8'h20, 8'h20);
    run_ticks(12, 1'b0, 1'b0, "edit_esc");
    send_byte(8'h08); check_wr_ptr(2'd0, "edit_BS_at_0");
  endtask

  // Write slot 1 while slot 1 is on display: old glyph for one clock, then the new one.
  task automatic test_same_cycle();
    int budget;
    bit done;
    budget = 400;
    done = 1'b0;
    send_byte(8'h4D);
    check_wr_ptr(2'd1, "same_M");
    while (!done && budget > 0) begin
      step();
      budget--;
      if (since_tick == 2 && bus0.char_idx === 2'd1 && bus0.blank === 1'b0) begin
        done = 1'b1;
        rx_byte = 8'h4E;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        tests_run++;
        if (bus0.font_addr[AW-1:3] !== 7'd0 || bus0.char_idx !== 2'd1) begin
          tests_failed++;
          $display("FAIL same_old: glyph=%0d idx=%0d, expected glyph=0 idx=1",
                   bus0.font_addr[AW-1:3], bus0.char_idx);
        end
        step();
        tests_run++;
        if (bus0.font_addr[AW-1:3] !== 7'd46 || bus0.char_idx !== 2'd1 || bus0.wr_ptr !== 2'd2) begin
          tests_failed++;
          $display("FAIL same_new: glyph=%0d idx=%0d wr=%0d, expected glyph=46 idx=1 wr=2",
                   bus0.font_addr[AW-1:3], bus0.char_idx, bus0.wr_ptr);
        end
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL same_timeout: slot 1 never displayed");
    end
  endtask

  task automatic test_reset_mid();
    dir = 1'b0;
    scroll_en = 1'b1;
    do_reset();
    send_byte(8'h41);
    send_byte(8'h7E);
    set_txt(8'h41, 8'h7E, 8'h20, 8'h20);
    run_ticks(9, 1'b0, 1'b1, "pre_mid");
    step();
    nrst = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    step();
    release_reset();
    set_txt(8'h20, 8'h20, 8'h20, 8'h20);
    run_ticks(14, 1'b0, 1'b1, "post_mid");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_scroll();
    test_edit();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
